// File: rtl/aileron_pkg.sv
// Shared types and constants for the rate-limited aileron servo.
// Valve patterns are packed as {v1e, v2e, v1d, v2d}.
package aileron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLEW   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam logic [3:0] VALVE_OFF = 4'b0000;
    localparam logic [3:0] VALVE_POS = 4'b1001;
    localparam logic [3:0] VALVE_NEG = 4'b0110;

endpackage

// File: rtl/aileron_prescaler.sv
// DIV-cycle tick generator; counts only while enabled, synchronous clear.
// tick is asserted on the cycle whose closing edge completes a DIV-cycle period.
module aileron_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aileron_servo.sv
// Rate-limited aileron actuator: clamps an accepted target, slews the position
// toward it by at most STEP per prescaler tick, then settles before re-arming.
module aileron_servo
    import aileron_pkg::*;
#(
    parameter int unsigned W        = 4,
    parameter int unsigned MAX_ANG  = 7,
    parameter int unsigned STEP     = 1,
    parameter int unsigned DIV      = 4,
    parameter int unsigned HOLD_CYC = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic signed [W-1:0] cmd_ang,
    output logic signed [W-1:0] pos,
    output logic                busy,
    output logic                sat,
    output logic                v1e,
    output logic                v2e,
    output logic                v1d,
    output logic                v2d
);

    localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic signed [W:0] MAX_S = (W + 1)'(MAX_ANG);
    localparam logic signed [W:0] STEP_S = (W + 1)'(STEP);

    state_e               state_q, state_d;
    logic signed [W-1:0]  pos_q, pos_d;
    logic signed [W-1:0]  tgt_q, tgt_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [3:0]           valve_q, valve_d;
    logic                 sat_q, sat_d;

    logic                 accept;
    logic                 tick;
    logic signed [W:0]    cmd_ext, pos_ext, tgt_ext;
    logic signed [W:0]    clamped;
    logic                 clip;
    logic signed [W:0]    diff, mag, step_amt, pos_nx;

    aileron_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_q == SLEW),
        .tick  (tick)
    );

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // All arithmetic is done one bit wider so target-pos cannot overflow.
    always_comb begin
        cmd_ext = {cmd_ang[W-1], cmd_ang};
        pos_ext = {pos_q[W-1], pos_q};
        tgt_ext = {tgt_q[W-1], tgt_q};

        clamped = cmd_ext;
        clip    = 1'b0;
        if (cmd_ext > MAX_S) begin
            clamped = MAX_S;
            clip    = 1'b1;
        end else if (cmd_ext < -MAX_S) begin
            clamped = -MAX_S;
            clip    = 1'b1;
        end

        diff     = tgt_ext - pos_ext;
        mag      = diff[W] ? -diff : diff;
        step_amt = (mag < STEP_S) ? mag : STEP_S;
        pos_nx   = diff[W] ? pos_ext - step_amt : pos_ext + step_amt;
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        hold_d  = hold_q;
        valve_d = valve_q;
        sat_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                valve_d = VALVE_OFF;
                if (accept) begin
                    tgt_d  = clamped[W-1:0];
                    sat_d  = clip;
                    hold_d = '0;
                    if (clamped != pos_ext) begin
                        state_d = SLEW;
                        valve_d = (clamped > pos_ext) ? VALVE_POS : VALVE_NEG;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SLEW: begin
                if (tick) begin
                    pos_d = pos_nx[W-1:0];
                    if (pos_nx == tgt_ext) begin
                        state_d = SETTLE;
                        valve_d = VALVE_OFF;
                        hold_d  = '0;
                    end
                end
            end
            SETTLE: begin
                valve_d = VALVE_OFF;
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valve_d = VALVE_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            hold_q  <= '0;
            valve_q <= VALVE_OFF;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
            valve_q <= valve_d;
            sat_q   <= sat_d;
        end
    end

    assign pos  = pos_q;
    assign busy = (state_q != IDLE);
    assign sat  = sat_q;
    assign {v1e, v2e, v1d, v2d} = valve_q;

endmodule

// File: tb/tb_aileron_servo.sv
// Directed bench for aileron_servo: default instance plus a STEP=3 instance
// sharing the same command stream.
module tb_aileron_servo;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic signed [3:0] cmd_ang;

    logic              ready_a, busy_a, sat_a, v1e_a, v2e_a, v1d_a, v2d_a;
    logic signed [3:0] pos_a;
    logic              ready_b, busy_b, sat_b, v1e_b, v2e_b, v1d_b, v2d_b;
    logic signed [3:0] pos_b;

    int passed = 0;
    int total  = 0;

    aileron_servo #(
        .W(4), .MAX_ANG(7), .STEP(1), .DIV(4), .HOLD_CYC(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
        .cmd_ang(cmd_ang), .pos(pos_a), .busy(busy_a), .sat(sat_a),
        .v1e(v1e_a), .v2e(v2e_a), .v1d(v1d_a), .v2d(v2d_a)
    );

    aileron_servo #(
        .W(4), .MAX_ANG(7), .STEP(3), .DIV(4), .HOLD_CYC(3)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
        .cmd_ang(cmd_ang), .pos(pos_b), .busy(busy_b), .sat(sat_b),
        .v1e(v1e_b), .v2e(v2e_b), .v1d(v1d_b), .v2d(v2d_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation word: {busy, cmd_ready, sat, v1e, v2e, v1d, v2d, pos}
    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_ang   = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [10:0] obs, exp;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        obs = {busy_a, ready_a, sat_a, v1e_a, v2e_a, v1d_a, v2d_a, pos_a};
        exp = 11'b01_0_0000_0000;
        total++;
        if (obs !== exp) $display("FAIL reset_held got %b want %b", obs, exp);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        obs = {busy_a, ready_a, sat_a, v1e_a, v2e_a, v1d_a, v2d_a, pos_a};
        total++;
        if (obs !== exp) $display("FAIL reset_release got %b want %b", obs, exp);
        else passed++;
    endtask

    task automatic test_move_pos3();
        logic [10:0] obs, exp;
        logic [3:0]  ep;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ang   = 4'sd3;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            ep  = (k >= 12) ? 4'd3 : 4'(k / 4);
            exp = {k < 15, k >= 15, 1'b0, (k < 12) ? 4'b1001 : 4'b0000, ep};
            obs = {busy_a, ready_a, sat_a, v1e_a, v2e_a, v1d_a, v2d_a, pos_a};
            total++;
            if (obs !== exp) $display("FAIL move_pos3 k=%0d got %b want %b", k, obs, exp);
            else passed++;
        end
    endtask

    task automatic test_sat_neg_and_ignore();
        logic [10:0] obs, exp;
        logic [3:0]  ep;
        do_reset();
        cmd_valid = 1'b1;
        cmd_ang   = -4'sd8;
        @(posedge clk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            cmd_ang = 4'sd5;
            if (k >= 29) cmd_valid = 1'b0;
            ep  = (k >= 28) ? 4'(-7) : 4'(-(k / 4));
            exp = {k < 31, k >= 31, k == 0, (k < 28) ? 4'b0110 : 4'b0000, ep};
            obs = {busy_a, ready_a, sat_a, v1e_a, v2e_a, v1d_a, v2d_a, pos_a};
            total++;
            if (obs !== exp) $display("FAIL sat_neg k=%0d got %b want %b", k, obs, exp);
            else passed++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_zero_move();
        logic [10:0] obs, exp;
        do_reset();
        cmd_valid = 1'b1;
        cmd_ang   = 4'sd0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            exp = {k < 3, k >= 3, 1'b0, 4'b0000, 4'd0};
            obs = {busy_a, ready_a, sat_a, v1e_a, v2e_a, v1d_a, v2d_a, pos_a};
            total++;
            if (obs !== exp) $display("FAIL zero_move k=%0d got %b want %b", k, obs, exp);
            else passed++;
        end
    endtask

    task automatic test_step3();
        logic [10:0] obs, exp;
        logic [3:0]  ep;
        do_reset();
        cmd_valid = 1'b1;
        cmd_ang   = 4'sd7;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            ep  = (k < 4) ? 4'd0 : (k < 8) ? 4'd3 : (k < 12) ? 4'd6 : 4'd7;
            exp = {k < 15, k >= 15, 1'b0, (k < 12) ? 4'b1001 : 4'b0000, ep};
            obs = {busy_b, ready_b, sat_b, v1e_b, v2e_b, v1d_b, v2d_b, pos_b};
            total++;
            if (obs !== exp) $display("FAIL step3 k=%0d got %b want %b", k, obs, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_slew();
        logic [10:0] obs, exp;
        do_reset();
        cmd_valid = 1'b1;
        cmd_ang   = 4'sd5;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        obs = {busy_a, ready_a, sat_a, v1e_a, v2e_a, v1d_a, v2d_a, pos_a};
        exp = 11'b10_0_1001_0010;
        total++;
        if (obs !== exp) $display("FAIL mid_slew_pre got %b want %b", obs, exp);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        obs = {busy_a, ready_a, sat_a, v1e_a, v2e_a, v1d_a, v2d_a, pos_a};
        exp = 11'b01_0_0000_0000;
        total++;
        if (obs !== exp) $display("FAIL mid_slew_async_reset got %b want %b", obs, exp);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_ang   = '0;
        test_reset();
        test_move_pos3();
        test_sat_neg_and_ignore();
        test_zero_move();
        test_step3();
        test_reset_mid_slew();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aileron_servo.md
# aileron_servo

Parametrised, rate-limited aileron actuator controller. Accepts a signed target deflection through a valid/ready handshake, clamps it to the mechanical limit, and slews an internal position register toward it by at most `STEP` per prescaler tick. During motion it drives the differential valve set (`v1e/v2e` left, `v1d/v2d` right), then settles before accepting the next command. It sits between the flight-control command path and the hydraulic valve drivers, replacing the purely combinational angle-to-valve decoder.

## Interface
- `W`, 4: angle width in bits, signed two's complement.
- `MAX_ANG`, 7: clamp limit, magnitude; must satisfy `MAX_ANG <= 2^(W-1)-1`.
- `STEP`, 1: maximum position change per tick, `1..MAX_ANG`.
- `DIV`, 4: clock cycles per slew tick, `>= 1`.
- `HOLD_CYC`, 3: settle duration in cycles, `>= 1`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_ang`  in  W  signed target deflection.
- `pos`  out  W  signed current position, registered.
- `busy`  out  1  high in SLEW or SETTLE.
- `sat`  out  1  one-cycle pulse when an accepted command was clamped.
- `v1e`, `v2e`, `v1d`, `v2d`  out  1 each  valve drives, registered.

## Operation
- Reset (async, immediate): state IDLE, `pos=0`, target 0, prescaler 0, all valves 0, `sat=0`, `busy=0`, `cmd_ready=1`. This applies mid-motion as well; no partial step survives.
- `cmd_ready` is a combinational decode of `state==IDLE`. A command is accepted on a clock edge where `cmd_valid && cmd_ready`. `cmd_valid` outside IDLE is ignored and has no side effects.
- On acceptance:
  - Target = `cmd_ang` clamped to `[-MAX_ANG, +MAX_ANG]`. `sat` pulses high for the next cycle iff clamping occurred.
  - Next state is SLEW if target != `pos`; otherwise SETTLE.
- States:
  - IDLE.
  - SLEW: prescaler counts `0..DIV-1`. On wrap, `pos += sign(diff)*min(STEP,|diff|)`, where `diff = target - pos` is computed in W+1 bits so it cannot overflow. The position never overshoots the target.
  - SLEW → SETTLE on the edge where the update makes `pos == target`.
  - SETTLE: counter runs `HOLD_CYC` cycles, then returns to IDLE.
- Valve patterns, registered alongside state/`pos`:
  - SLEW with target > `pos`: `v1e=1, v2d=1`, others 0.
  - SLEW with target < `pos`: `v2e=1, v1d=1`, others 0.
  - IDLE and SETTLE: all 0.
  - The two members of a side pair are never both high.

## Timing
- Acceptance edge at cycle t: `busy=1` and valves active from t+1.
- First `pos` change at edge t+DIV. Subsequent changes every DIV cycles.
- Move of N ticks (`N = ceil(|target-pos0|/STEP)`):
  - Final `pos` update at edge t+N·DIV. Valves go to 0 on that same edge.
  - SETTLE lasts cycles t+N·DIV+1 … t+N·DIV+HOLD_CYC.
  - `cmd_ready=1` again from t+N·DIV+HOLD_CYC+1.
- Zero-move command: SETTLE from t+1, IDLE at t+HOLD_CYC+1.
- `sat` is high exactly during cycle t+1.

## Structure
- Package `aileron_pkg`: state enum (IDLE, SLEW, SETTLE) and the valve-pattern constants (`VALVE_OFF`, `VALVE_POS`, `VALVE_NEG` as 4-bit `{v1e,v2e,v1d,v2d}`).
- Sub-module `aileron_prescaler`: DIV-cycle tick generator with synchronous clear, asynchronous `rst_n`. It is cleared on acceptance and free of state knowledge.
- Top module holds the FSM, target/position registers, clamp, and settle counter.

## Test plan
Defaults are W=4, MAX_ANG=7, STEP=1, DIV=4, HOLD_CYC=3 unless noted.
- Reset release → `pos=0`, valves 0000, `busy=0`, `cmd_ready=1`, `sat=0`.
- Accept `cmd_ang=3` at t → `v1e=v2d=1` from t+1; `pos` 1,2,3 at edges t+4, t+8, t+12; valves 0 at t+12; `cmd_ready=1` at t+16.
- Accept `cmd_ang=-8` → `sat=1` for one cycle, target −7; `v2e=v1d=1`; `pos` reaches −7 at edge t+28.
- STEP=3, from `pos=0` accept `cmd_ang=7` → `pos` 3, 6, 7 with no overshoot; SETTLE follows the third tick.
- Accept `cmd_ang=0` at `pos=0` → no valve activity, `busy` high for 3 cycles; `cmd_valid` held with a new angle during SLEW is ignored and the target is unchanged.
- Drive `rst_n` low mid-SLEW at `pos=2` → `pos=0`, valves 0000, `cmd_ready=1` immediately, without waiting for a clock edge.
